// File: rtl/fmt_pkg.sv
// Shared definitions for the formatted byte-stream blocks.
//   BYTE_W        width of one stream byte
//   MAX_BPW       largest supported word width in bytes
//   byte_t        one stream byte
//   pack_state_e  packer occupancy: EMPTY (no lanes filled) / FILL (partial word)
//   keep_mask()   contiguous lane-enable mask with the low nbytes bits set
package fmt_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_BPW = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } pack_state_e;

    // One extra bit so that nbytes == MAX_BPW yields all ones after the subtract.
    function automatic logic [MAX_BPW-1:0] keep_mask(input logic [3:0] nbytes);
        logic [MAX_BPW:0] m;
        m = ((MAX_BPW+1)'(1) << nbytes) - (MAX_BPW+1)'(1);
        return m[MAX_BPW-1:0];
    endfunction

endpackage

// File: rtl/fmt_idle_timer.sv
// Idle counter for the byte packer's partial-word flush.
//   clk, reset_n  clock / asynchronous active-low reset
//   clr           zero the counter (takes priority over inc)
//   inc           count one idle cycle; saturates at TIMEOUT
//   expired       counter has reached TIMEOUT
// With TIMEOUT == 0 the timer is absent and expired is tied low.
module fmt_idle_timer #(
    parameter int TIMEOUT = 16,
    parameter int W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            logic [W-1:0] idle_q;
            logic [W-1:0] idle_d;

            always_comb begin
                idle_d = idle_q;
                if (clr) begin
                    idle_d = '0;
                end else if (inc && (idle_q != W'(TIMEOUT))) begin
                    idle_d = idle_q + W'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    idle_q <= '0;
                end else begin
                    idle_q <= idle_d;
                end
            end

            assign expired = (idle_q == W'(TIMEOUT));
        end else begin : g_off
            logic unused_tmr;
            assign unused_tmr = &{1'b0, clk, reset_n, clr, inc};
            assign expired    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/fmt_byte_packer.sv
// Packs an 8-bit valid/ready byte stream little-endian into BYTES_PER_WORD-byte
// words with a registered valid/ready output. A word is emitted when the last
// lane fills, on in_last, or after FLUSH_TIMEOUT idle cycles with a partial word.
//   clk, reset_n          clock / asynchronous active-low reset
//   in_valid/in_ready     byte handshake (in_ready depends only on the output slot)
//   in_data, in_last      byte and end-of-frame marker
//   out_valid/out_ready   word handshake
//   out_data              packed word, first byte in [7:0], unused lanes zero
//   out_keep              contiguous lane enables from bit 0
//   out_last              word closes a frame (never set on a timeout flush)
//   word_count            words handed off since reset, wrapping
module fmt_byte_packer
    import fmt_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int FLUSH_TIMEOUT  = 16,
    parameter int CNT_W          = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BYTE_W-1:0]             in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]     out_keep,
    output logic                          out_last,
    output logic [CNT_W-1:0]              word_count
);

    localparam int DATA_W = BYTE_W * BYTES_PER_WORD;
    // One bit more than a lane index so lane_cnt+1 can express a full word.
    localparam int LANE_W = $clog2(BYTES_PER_WORD) + 1;

    pack_state_e          state_q, state_d;
    logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
    logic [DATA_W-1:0]    asm_q, asm_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [BYTES_PER_WORD-1:0] out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;
    logic [CNT_W-1:0]     word_count_q, word_count_d;

    logic                 slot_free;
    logic                 accept;
    logic                 handoff;
    logic                 complete;
    logic                 flush;
    logic                 tmr_expired;
    logic [DATA_W-1:0]    asm_wr;
    logic [MAX_BPW-1:0]   keep_inc;
    logic [MAX_BPW-1:0]   keep_cur;

    // The output slot can take a new word when empty or emptying this cycle.
    assign slot_free = !out_valid_q || out_ready;
    assign accept    = in_valid && slot_free;
    assign handoff   = out_valid_q && out_ready;
    assign complete  = accept && ((lane_cnt_q == LANE_W'(BYTES_PER_WORD - 1)) || in_last);
    // An accepted byte always beats a pending timeout.
    assign flush     = !accept && (state_q == FILL) && tmr_expired && slot_free;

    assign keep_inc  = keep_mask(4'(lane_cnt_q + LANE_W'(1)));
    assign keep_cur  = keep_mask(4'(lane_cnt_q));

    // Assembly register with the incoming byte dropped into the current lane.
    always_comb begin
        asm_wr = asm_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (lane_cnt_q == LANE_W'(i)) begin
                asm_wr[i*BYTE_W +: BYTE_W] = in_data;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        asm_d        = asm_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        word_count_d = word_count_q;

        if (handoff) begin
            word_count_d = word_count_q + CNT_W'(1);
            out_valid_d  = 1'b0;
        end

        if (complete) begin
            out_valid_d = 1'b1;
            out_data_d  = asm_wr;
            out_keep_d  = keep_inc[BYTES_PER_WORD-1:0];
            out_last_d  = in_last;
            asm_d       = '0;
            lane_cnt_d  = '0;
            state_d     = EMPTY;
        end else if (accept) begin
            asm_d       = asm_wr;
            lane_cnt_d  = lane_cnt_q + LANE_W'(1);
            state_d     = FILL;
        end else if (flush) begin
            out_valid_d = 1'b1;
            out_data_d  = asm_q;
            out_keep_d  = keep_cur[BYTES_PER_WORD-1:0];
            out_last_d  = 1'b0;
            asm_d       = '0;
            lane_cnt_d  = '0;
            state_d     = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            lane_cnt_q   <= '0;
            asm_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            asm_q        <= asm_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            word_count_q <= word_count_d;
        end
    end

    // Idle time only accumulates while a partial word is held.
    fmt_idle_timer #(
        .TIMEOUT (FLUSH_TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept || flush || (state_q == EMPTY)),
        .inc     (state_q == FILL),
        .expired (tmr_expired)
    );

    assign in_ready   = slot_free;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_keep   = out_keep_q;
    assign out_last   = out_last_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_fmt_byte_packer.sv
module tb_fmt_byte_packer;

    localparam int BPW = 4;
    localparam int FT  = 16;
    localparam int CW  = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    fmt_byte_packer #(
        .BYTES_PER_WORD (BPW),
        .FLUSH_TIMEOUT  (FT),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .word_count (word_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending bytes in a queue, one output slot, idle cycle count.
    logic [7:0]  pend[$];
    int          m_idle;
    logic        m_ov, m_last;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic [15:0] m_cnt;
    logic [31:0] hq[$];   // words handed off, in order

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        logic        e_ov;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_idle = 0;
        m_ov   = 1'b0;
        m_data = '0;
        m_keep = '0;
        m_last = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic emit(input logic l);
        int n;
        n = pend.size();
        m_data = '0;
        for (int i = 0; i < n; i++) m_data = m_data | (32'(pend[i]) << (8 * i));
        m_keep = 4'((32'd1 << n) - 1);
        m_last = l;
        m_ov   = 1'b1;
        pend.delete();
    endtask

    task automatic model_update(input logic v, input logic [7:0] d, input logic l, input logic r);
        logic ready, acc;
        ready = !m_ov || r;
        acc   = v && ready;
        if (m_ov && r) begin
            m_cnt = m_cnt + 16'd1;
            hq.push_back(m_data);
            m_ov = 1'b0;
        end
        if (acc) begin
            pend.push_back(d);
            m_idle = 0;
            if (pend.size() == BPW || l) emit(l);
        end else if (pend.size() != 0) begin
            if (m_idle == FT && ready) begin
                emit(1'b0);
                m_idle = 0;
            end else if (m_idle < FT) begin
                m_idle++;
            end
        end
    endtask

    task automatic cmp_outputs();
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", out_data, m_data);
            chk("out_keep", out_keep, m_keep);
            chk("out_last", out_last, m_last);
        end
        chk("word_count", word_count, m_cnt);
    endtask

    // One clock: drive inputs, check in_ready mid-cycle, advance model, compare after edge.
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r,
                        output logic rdy);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        rdy = !m_ov || r;
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (reset_n) model_update(v, d, l, r);
        else model_reset();
        #1;
        cmp_outputs();
    endtask

    task automatic s(input logic v, input logic [7:0] d, input logic l, input logic r);
        logic rdy;
        step(v, d, l, r, rdy);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_out_keep"}, out_keep, 4'h0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_word_count"}, word_count, 16'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy;
        logic sparse;
        logic [7:0] b4 [8];
        int idx, hold;
        logic started;
        logic [15:0] c0;

        // Tests 1 and 2 back to back; expectations are the state right after each edge.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 16'd0};
        tbl[4] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd1};
        tbl[5] = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1, 16'd1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // Table-driven: full word, then a two-byte frame closed by in_last.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, rdy);
            chk("tbl_valid", out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk("tbl_data", out_data, tbl[i].e_data);
                chk("tbl_keep", out_keep, tbl[i].e_keep);
                chk("tbl_last", out_last, tbl[i].e_last);
            end
            chk("tbl_count", word_count, tbl[i].e_cnt);
        end

        // Timeout flush: the counter reaches 16 after 16 idle cycles and the
        // flush is registered on the following edge.
        s(1'b1, 8'h01, 1'b0, 1'b1);
        s(1'b1, 8'h02, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            s(1'b0, 8'h00, 1'b0, 1'b1);
            chk("flush_early", out_valid, 1'b0);
        end
        s(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush_valid", out_valid, 1'b1);
        chk("flush_data", out_data, 32'h00000201);
        chk("flush_keep", out_keep, 4'h3);
        chk("flush_last", out_last, 1'b0);
        s(1'b0, 8'h00, 1'b0, 1'b1);

        // A byte arriving at idle=15 restarts the timer.
        s(1'b1, 8'h01, 1'b0, 1'b1);
        s(1'b1, 8'h02, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) s(1'b0, 8'h00, 1'b0, 1'b1);
        s(1'b1, 8'h03, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            s(1'b0, 8'h00, 1'b0, 1'b1);
            chk("restart_noflush", out_valid, 1'b0);
        end
        s(1'b0, 8'h00, 1'b0, 1'b1);
        chk("restart_valid", out_valid, 1'b1);
        chk("restart_data", out_data, 32'h00030201);
        chk("restart_keep", out_keep, 4'h7);
        s(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: 5 cycles of out_ready=0 after the first word appears.
        for (int i = 0; i < 8; i++) b4[i] = 8'h10 + 8'(i);
        hq.delete();
        c0 = m_cnt;
        idx = 0;
        hold = 0;
        started = 1'b0;
        for (int t = 0; t < 40 && !(idx == 8 && hq.size() == 2); t++) begin
            logic r;
            r = !(started && hold < 5);
            step(idx < 8, (idx < 8) ? b4[idx] : 8'h00, 1'b0, r, rdy);
            if (idx < 8 && rdy) idx++;
            if (started && hold < 5) hold++;
            if (m_ov) started = 1'b1;
        end
        chk("bp_words", hq.size(), 2);
        if (hq.size() == 2) begin
            chk("bp_word0", hq[0], 32'h13121110);
            chk("bp_word1", hq[1], 32'h17161514);
        end
        chk("bp_count", word_count, c0 + 16'd2);

        // Reset mid-frame: outputs return to reset values without a clock edge.
        s(1'b1, 8'hA1, 1'b0, 1'b1);
        s(1'b1, 8'hA2, 1'b0, 1'b1);
        s(1'b1, 8'hA3, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        s(1'b0, 8'h00, 1'b0, 1'b1);
        reset_n = 1'b1;
        s(1'b1, 8'hB1, 1'b0, 1'b1);
        s(1'b1, 8'hB2, 1'b0, 1'b1);
        s(1'b1, 8'hB3, 1'b0, 1'b1);
        s(1'b1, 8'hB4, 1'b0, 1'b1);
        chk("post_rst_data", out_data, 32'hB4B3B2B1);
        chk("post_rst_keep", out_keep, 4'hF);
        s(1'b0, 8'h00, 1'b0, 1'b1);

        // Counter wrap: single-byte frames every cycle, one handoff per cycle.
        reset_n = 1'b0;
        s(1'b0, 8'h00, 1'b0, 1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 65536; i++) s(1'b1, 8'(i), 1'b1, 1'b1);
        chk("cnt_ffff", word_count, 16'hFFFF);
        chk("single_keep", out_keep, 4'h1);
        chk("single_last", out_last, 1'b1);
        s(1'b0, 8'h00, 1'b0, 1'b1);
        chk("cnt_wrap", word_count, 16'h0000);

        // Random traffic with dense and sparse phases so timeouts also fire.
        sparse = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            logic v;
            if (t % 60 == 0) sparse = ($urandom_range(0, 2) == 0);
            v = sparse ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) < 8);
            s(v, 8'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
